// File: rtl/commit_pair_sync.sv
// Lockstep commit scheduler: pairs retire events from two core copies, stalls the leader, compares each pair.
// Optional partner-wait timeout is built when COMMIT_SYNC_TIMEOUT_EN is defined.
module commit_pair_sync #(
    parameter int XLEN    = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit_valid_a,
    input  logic [XLEN-1:0]  commit_pc_a,
    input  logic             commit_mem_a,
    input  logic [XLEN-1:0]  commit_addr_a,
    input  logic             commit_valid_b,
    input  logic [XLEN-1:0]  commit_pc_b,
    input  logic             commit_mem_b,
    input  logic [XLEN-1:0]  commit_addr_b,
    output logic             stall_a,
    output logic             stall_b,
    output logic             pair_valid,
    output logic             pair_match,
    output logic             mismatch,
    output logic             protocol_err,
    output logic             timeout,
    output logic [CNT_W-1:0] pair_count
);

    // state  | meaning
    // IDLE   | no event held
    // HOLD_A | A's event held, A stalled, waiting for B
    // HOLD_B | B's event held, B stalled, waiting for A
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD_A = 2'd1,
        S_HOLD_B = 2'd2
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("commit_pair_sync: TIMEOUT must be in 1..65535");
    end

    state_t          r_state;
    state_t          w_next_state;

    logic [XLEN-1:0] r_hold_pc;
    logic            r_hold_mem;
    logic [XLEN-1:0] r_hold_addr;

    logic            w_cmp;
    logic            w_match;
    logic            w_capture_a;
    logic            w_capture_b;
    logic            w_proto;
    logic            w_tmo;
    logic            w_tmo_hit;

    logic [XLEN-1:0] w_pc_a;
    logic            w_mem_a;
    logic [XLEN-1:0] w_addr_a;
    logic [XLEN-1:0] w_pc_b;
    logic            w_mem_b;
    logic [XLEN-1:0] w_addr_b;

    logic             r_stall_a;
    logic             r_stall_b;
    logic             r_pair_valid;
    logic             r_pair_match;
    logic             r_mismatch;
    logic             r_protocol_err;
    logic [CNT_W-1:0] r_pair_count;

    logic             w_stall_a_d;
    logic             w_stall_b_d;
    logic             w_mismatch_d;
    logic             w_protocol_err_d;
    logic [CNT_W-1:0] w_pair_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cmp        = 1'b0;
        w_capture_a  = 1'b0;
        w_capture_b  = 1'b0;
        w_proto      = 1'b0;
        w_tmo        = 1'b0;
        w_pc_a       = commit_pc_a;
        w_mem_a      = commit_mem_a;
        w_addr_a     = commit_addr_a;
        w_pc_b       = commit_pc_b;
        w_mem_b      = commit_mem_b;
        w_addr_b     = commit_addr_b;
        case (r_state)
            S_IDLE: begin
                if (commit_valid_a && commit_valid_b) begin
                    w_cmp = 1'b1;
                end else if (commit_valid_a) begin
                    w_capture_a  = 1'b1;
                    w_next_state = S_HOLD_A;
                end else if (commit_valid_b) begin
                    w_capture_b  = 1'b1;
                    w_next_state = S_HOLD_B;
                end
            end
            S_HOLD_A: begin
                w_pc_a   = r_hold_pc;
                w_mem_a  = r_hold_mem;
                w_addr_a = r_hold_addr;
                w_proto  = commit_valid_a;
                // a partner commit wins over a timeout landing on the same edge
                if (commit_valid_b) begin
                    w_cmp        = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_tmo        = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_HOLD_B: begin
                w_pc_b   = r_hold_pc;
                w_mem_b  = r_hold_mem;
                w_addr_b = r_hold_addr;
                w_proto  = commit_valid_b;
                if (commit_valid_a) begin
                    w_cmp        = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_tmo        = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_match = (w_pc_a == w_pc_b) && (w_mem_a == w_mem_b) &&
                     (!w_mem_a || (w_addr_a == w_addr_b));

    always_comb begin
        w_stall_a_d      = (w_next_state == S_HOLD_A);
        w_stall_b_d      = (w_next_state == S_HOLD_B);
        w_mismatch_d     = r_mismatch | (w_cmp & ~w_match) | w_tmo;
        w_protocol_err_d = r_protocol_err | w_proto;
        w_pair_count_d   = r_pair_count;
        if (w_cmp && (r_pair_count != {CNT_W{1'b1}})) begin
            w_pair_count_d = r_pair_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_a      <= 1'b0;
            r_stall_b      <= 1'b0;
            r_pair_valid   <= 1'b0;
            r_pair_match   <= 1'b0;
            r_mismatch     <= 1'b0;
            r_protocol_err <= 1'b0;
            r_pair_count   <= '0;
        end else begin
            r_stall_a      <= w_stall_a_d;
            r_stall_b      <= w_stall_b_d;
            r_pair_valid   <= w_cmp;
            r_pair_match   <= w_cmp & w_match;
            r_mismatch     <= w_mismatch_d;
            r_protocol_err <= w_protocol_err_d;
            r_pair_count   <= w_pair_count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_pc   <= '0;
            r_hold_mem  <= 1'b0;
            r_hold_addr <= '0;
        end else if (w_capture_a) begin
            r_hold_pc   <= commit_pc_a;
            r_hold_mem  <= commit_mem_a;
            r_hold_addr <= commit_addr_a;
        end else if (w_capture_b) begin
            r_hold_pc   <= commit_pc_b;
            r_hold_mem  <= commit_mem_b;
            r_hold_addr <= commit_addr_b;
        end
    end

`ifdef COMMIT_SYNC_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    logic [15:0] r_wait;
    logic [15:0] w_wait_inc;
    logic        r_timeout;

    // w_wait_inc counts cycles spent in HOLD including the current one
    assign w_wait_inc = r_wait + 16'd1;
    assign w_tmo_hit  = (r_state != S_IDLE) && (w_wait_inc == TIMEOUT_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait    <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            if (w_capture_a || w_capture_b) begin
                r_wait <= 16'd0;
            end else if (r_state != S_IDLE) begin
                r_wait <= w_wait_inc;
            end
            r_timeout <= r_timeout | w_tmo;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_tmo_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign stall_a      = r_stall_a;
    assign stall_b      = r_stall_b;
    assign pair_valid   = r_pair_valid;
    assign pair_match   = r_pair_match;
    assign mismatch     = r_mismatch;
    assign protocol_err = r_protocol_err;
    assign pair_count   = r_pair_count;

endmodule

// File: tb/tb_commit_pair_sync.sv
// Directed bench for commit_pair_sync; main instance uses TIMEOUT=4, a second instance uses CNT_W=4.
// Timeout scenario follows COMMIT_SYNC_TIMEOUT_EN.
module tb_commit_pair_sync;

    logic        clk;
    logic        rst_n;
    logic        va, ma, vb, mb;
    logic [31:0] pca, addra, pcb, addrb;

    logic        stall_a, stall_b, pair_valid, pair_match, mismatch, protocol_err, timeout;
    logic [15:0] pair_count;
    logic        s_stall_a, s_stall_b, s_pair_valid, s_pair_match, s_mismatch, s_protocol_err, s_timeout;
    logic [3:0]  s_pair_count;

    int total = 0;
    int bad   = 0;

    commit_pair_sync #(.XLEN(32), .CNT_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid_a(va), .commit_pc_a(pca), .commit_mem_a(ma), .commit_addr_a(addra),
        .commit_valid_b(vb), .commit_pc_b(pcb), .commit_mem_b(mb), .commit_addr_b(addrb),
        .stall_a(stall_a), .stall_b(stall_b), .pair_valid(pair_valid), .pair_match(pair_match),
        .mismatch(mismatch), .protocol_err(protocol_err), .timeout(timeout), .pair_count(pair_count)
    );

    commit_pair_sync #(.XLEN(32), .CNT_W(4), .TIMEOUT(64)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .commit_valid_a(va), .commit_pc_a(pca), .commit_mem_a(ma), .commit_addr_a(addra),
        .commit_valid_b(vb), .commit_pc_b(pcb), .commit_mem_b(mb), .commit_addr_b(addrb),
        .stall_a(s_stall_a), .stall_b(s_stall_b), .pair_valid(s_pair_valid), .pair_match(s_pair_match),
        .mismatch(s_mismatch), .protocol_err(s_protocol_err), .timeout(s_timeout), .pair_count(s_pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_in();
        va = 0; pca = 0; ma = 0; addra = 0;
        vb = 0; pcb = 0; mb = 0; addrb = 0;
    endtask

    task automatic drive_a(input logic [31:0] pc, input logic m, input logic [31:0] ad);
        va = 1; pca = pc; ma = m; addra = ad;
    endtask

    task automatic drive_b(input logic [31:0] pc, input logic m, input logic [31:0] ad);
        vb = 1; pcb = pc; mb = m; addrb = ad;
    endtask

    // one clock edge, then sample 1ns later and return inputs to idle
    task automatic cyc();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_in();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        do_reset();
        got = {stall_a, stall_b, pair_valid, pair_match, mismatch, protocol_err, timeout, 2'b00};
        total++;
        if (got !== 9'd0) begin
            bad++; $display("FAIL reset_flags got=%b exp=%b", got, 9'd0);
        end
        total++;
        if (pair_count !== 16'd0) begin
            bad++; $display("FAIL reset_count got=%0d exp=0", pair_count);
        end
        total++;
        if (s_pair_count !== 4'd0) begin
            bad++; $display("FAIL reset_sat_count got=%0d exp=0", s_pair_count);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive_a(32'h200, 0, 32'h0); drive_b(32'h200, 0, 32'h0);
        cyc();
        total++;
        if ({pair_valid, pair_match, stall_a, stall_b} !== 4'b1100) begin
            bad++; $display("FAIL simul_pair got=%b exp=1100", {pair_valid, pair_match, stall_a, stall_b});
        end
        total++;
        if (pair_count !== 16'd1) begin
            bad++; $display("FAIL simul_count got=%0d exp=1", pair_count);
        end
        cyc();
        total++;
        if (pair_valid !== 1'b0) begin
            bad++; $display("FAIL simul_pulse_width got=%b exp=0", pair_valid);
        end
    endtask

    task automatic test_a_leads();
        do_reset();
        drive_a(32'h104, 1, 32'h80);
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if ({stall_a, stall_b, pair_valid} !== 3'b100) begin
                bad++; $display("FAIL lead_stall_%0d got=%b exp=100", i, {stall_a, stall_b, pair_valid});
            end
        end
        drive_b(32'h104, 1, 32'h84);
        cyc();
        total++;
        if ({stall_a, pair_valid, pair_match, mismatch} !== 4'b0101) begin
            bad++; $display("FAIL lead_compare got=%b exp=0101", {stall_a, pair_valid, pair_match, mismatch});
        end
        cyc(); cyc();
        total++;
        if ({mismatch, pair_valid, pair_count} !== {1'b1, 1'b0, 16'd1}) begin
            bad++; $display("FAIL lead_sticky got=%b/%b/%0d exp=1/0/1", mismatch, pair_valid, pair_count);
        end
    endtask

    task automatic test_protocol();
        do_reset();
        drive_b(32'h300, 1, 32'h40);
        cyc();
        total++;
        if ({stall_a, stall_b} !== 2'b01) begin
            bad++; $display("FAIL proto_stall got=%b exp=01", {stall_a, stall_b});
        end
        drive_b(32'h999, 0, 32'h0);
        cyc();
        total++;
        if ({protocol_err, stall_b, pair_valid} !== 3'b110) begin
            bad++; $display("FAIL proto_flag got=%b exp=110", {protocol_err, stall_b, pair_valid});
        end
        drive_a(32'h300, 1, 32'h40);
        cyc();
        total++;
        if ({pair_valid, pair_match, stall_b, mismatch, protocol_err} !== 5'b11001) begin
            bad++; $display("FAIL proto_held_compare got=%b exp=11001",
                            {pair_valid, pair_match, stall_b, mismatch, protocol_err});
        end
    endtask

    task automatic test_compare_rule();
        do_reset();
        // addresses differ but no memory request: match
        drive_a(32'h40, 0, 32'h11); drive_b(32'h40, 0, 32'h22);
        cyc();
        total++;
        if ({pair_valid, pair_match, mismatch} !== 3'b110) begin
            bad++; $display("FAIL rule_addr_dontcare got=%b exp=110", {pair_valid, pair_match, mismatch});
        end
        drive_a(32'h40, 1, 32'h11); drive_b(32'h40, 0, 32'h11);
        cyc();
        total++;
        if ({pair_valid, pair_match, mismatch} !== 3'b101) begin
            bad++; $display("FAIL rule_mem_diff got=%b exp=101", {pair_valid, pair_match, mismatch});
        end
        drive_a(32'h44, 0, 32'h0); drive_b(32'h48, 0, 32'h0);
        cyc();
        total++;
        if ({pair_valid, pair_match, pair_count} !== {2'b10, 16'd3}) begin
            bad++; $display("FAIL rule_pc_diff got=%b/%0d exp=10/3", {pair_valid, pair_match}, pair_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_a(32'h10, 0, 32'h1); drive_b(32'h10, 0, 32'h2);
        cyc();
        drive_a(32'h14, 0, 32'h0); drive_b(32'h14, 0, 32'h0);
        total++;
        if ({pair_valid, pair_match} !== 2'b11) begin
            bad++; $display("FAIL b2b_first got=%b exp=11", {pair_valid, pair_match});
        end
        cyc();
        total++;
        if ({pair_valid, pair_match, pair_count} !== {2'b11, 16'd2}) begin
            bad++; $display("FAIL b2b_second got=%b/%0d exp=11/2", {pair_valid, pair_match}, pair_count);
        end
        drive_a(32'h18, 0, 32'h0);
        cyc();
        // held A must pair with B even though A also (illegally) commits this edge
        drive_a(32'h1C, 0, 32'h0); drive_b(32'h18, 0, 32'h0);
        cyc();
        total++;
        if ({pair_valid, pair_match, protocol_err, stall_a, mismatch} !== 5'b11100) begin
            bad++; $display("FAIL b2b_hold_both got=%b exp=11100",
                            {pair_valid, pair_match, protocol_err, stall_a, mismatch});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive_a(32'h500, 0, 32'h0);
`ifdef COMMIT_SYNC_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if ({stall_a, timeout} !== 2'b10) begin
                bad++; $display("FAIL tmo_wait_%0d got=%b exp=10", i, {stall_a, timeout});
            end
        end
        cyc();
        total++;
        if ({stall_a, timeout, mismatch, pair_valid} !== 4'b0110) begin
            bad++; $display("FAIL tmo_fire got=%b exp=0110", {stall_a, timeout, mismatch, pair_valid});
        end
        total++;
        if (pair_count !== 16'd0) begin
            bad++; $display("FAIL tmo_count got=%0d exp=0", pair_count);
        end
        // back in IDLE: a fresh simultaneous pair compares normally
        drive_a(32'h504, 0, 32'h0); drive_b(32'h504, 0, 32'h0);
        cyc();
        total++;
        if ({pair_valid, pair_match, pair_count} !== {2'b11, 16'd1}) begin
            bad++; $display("FAIL tmo_idle_after got=%b/%0d exp=11/1", {pair_valid, pair_match}, pair_count);
        end
`else
        begin
            int drops = 0;
            for (int i = 0; i < 110; i++) begin
                cyc();
                if (stall_a !== 1'b1 || timeout !== 1'b0) drops++;
            end
            total++;
            if (drops != 0) begin
                bad++; $display("FAIL notmo_hold got=%0d_drops exp=0", drops);
            end
            total++;
            if ({mismatch, pair_valid} !== 2'b00) begin
                bad++; $display("FAIL notmo_flags got=%b exp=00", {mismatch, pair_valid});
            end
        end
`endif
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        drive_a(32'h600, 1, 32'h20);
        cyc();
        total++;
        if (stall_a !== 1'b1) begin
            bad++; $display("FAIL rmid_pre got=%b exp=1", stall_a);
        end
        #1 rst_n = 0;
        #1;
        total++;
        if ({stall_a, stall_b, pair_valid, pair_match, mismatch, protocol_err, timeout, pair_count} !== 23'd0) begin
            bad++; $display("FAIL rmid_async got=%b/%0d exp=0/0",
                            {stall_a, stall_b, pair_valid, pair_match, mismatch, protocol_err, timeout}, pair_count);
        end
        @(posedge clk);
        #1 rst_n = 1;
        drive_a(32'h700, 0, 32'h0); drive_b(32'h700, 0, 32'h0);
        cyc();
        total++;
        if ({pair_valid, pair_match, pair_count} !== {2'b11, 16'd1}) begin
            bad++; $display("FAIL rmid_after got=%b/%0d exp=11/1", {pair_valid, pair_match}, pair_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_a(32'h1000 + 4 * i, 0, 32'h0); drive_b(32'h1000 + 4 * i, 0, 32'h0);
            cyc();
        end
        total++;
        if (s_pair_count !== 4'd15) begin
            bad++; $display("FAIL sat_count got=%0d exp=15", s_pair_count);
        end
        total++;
        if (pair_count !== 16'd20) begin
            bad++; $display("FAIL sat_wide_count got=%0d exp=20", pair_count);
        end
        drive_a(32'h2000, 0, 32'h0); drive_b(32'h2000, 0, 32'h0);
        cyc();
        total++;
        if ({s_pair_valid, s_pair_match, s_mismatch, s_pair_count} !== {3'b110, 4'd15}) begin
            bad++; $display("FAIL sat_hold got=%b/%0d exp=110/15",
                            {s_pair_valid, s_pair_match, s_mismatch}, s_pair_count);
        end
        total++;
        if ({s_stall_a, s_stall_b, s_protocol_err, s_timeout} !== 4'b0000) begin
            bad++; $display("FAIL sat_flags got=%b exp=0000", {s_stall_a, s_stall_b, s_protocol_err, s_timeout});
        end
    endtask

    initial begin
        rst_n = 0;
        idle_in();
        test_reset();
        test_simultaneous();
        test_a_leads();
        test_protocol();
        test_compare_rule();
        test_back_to_back();
        test_timeout();
        test_reset_mid_hold();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
